// File: rtl/cavlc_blk_sched.sv
// cavlc_blk_sched: walks a frame's macroblocks in raster order and each MB's 16 luma 4x4
// blocks in H.264 index order, issuing block coordinates under an in-flight limit.
module cavlc_blk_sched #(
   parameter int MAX_INFLIGHT = 2,
   parameter int CNT_W        = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [5:0]  frame_w_mb,
   input  logic [5:0]  frame_h_mb,
   input  logic        cavlc_cnt_ready,
   input  logic        cavlc_enc_valid,
   input  logic        packer_ready,
   output logic        intra_valid,
   output logic [9:0]  topleft_x,
   output logic [9:0]  topleft_y,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] blk_done_cnt,
   output logic        err_underflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [5:0]       w_mb, w_mb_nxt;
   logic [5:0]       h_mb, h_mb_nxt;
   logic [5:0]       mb_x, mb_x_nxt;
   logic [5:0]       mb_y, mb_y_nxt;
   logic [3:0]       blk_idx, blk_idx_nxt;
   logic [CNT_W-1:0] inflight, inflight_nxt;
   logic             intra_valid_nxt;
   logic [9:0]       topleft_x_nxt, topleft_y_nxt;
   logic             frame_done_nxt;
   logic [15:0]      blk_done_cnt_nxt;
   logic             err_underflow_nxt;

   logic             xfer, retire, underflow_hit, room, last_blk;
   logic [5:0]       adv_mb_x, adv_mb_y;
   logic [3:0]       adv_blk;

   // Block index bits interleave as {y1,x1,y0,x0}, giving the Z-order walk inside an MB.
   function automatic logic [9:0] px_x(input logic [5:0] mb, input logic [3:0] blk);
      return {mb, blk[2], blk[0], 2'b00};
   endfunction

   function automatic logic [9:0] px_y(input logic [5:0] mb, input logic [3:0] blk);
      return {mb, blk[3], blk[1], 2'b00};
   endfunction

   assign xfer          = intra_valid && cavlc_cnt_ready;
   assign retire        = cavlc_enc_valid && packer_ready;
   assign underflow_hit = retire && (inflight == '0);
   assign busy          = (state != IDLE);
   assign last_blk      = (blk_idx == 4'd15) && (mb_x == w_mb - 6'd1) && (mb_y == h_mb - 6'd1);

   // A retire with nothing in flight is flagged and ignored so the counter stays at 0.
   always_comb begin
      inflight_nxt = inflight;
      case ({xfer, retire && !underflow_hit})
         2'b10:   inflight_nxt = inflight + CNT_W'(1);
         2'b01:   inflight_nxt = inflight - CNT_W'(1);
         default: inflight_nxt = inflight;
      endcase
   end

   assign room = (inflight_nxt < CNT_W'(MAX_INFLIGHT));

   always_comb begin
      adv_blk  = blk_idx + 4'd1;
      adv_mb_x = mb_x;
      adv_mb_y = mb_y;
      if (blk_idx == 4'd15) begin
         if (mb_x == w_mb - 6'd1) begin
            adv_mb_x = '0;
            adv_mb_y = mb_y + 6'd1;
         end else begin
            adv_mb_x = mb_x + 6'd1;
         end
      end
   end

   always_comb begin
      // NOTE: every *_nxt is given a default before the case so no path infers a latch.
      state_nxt         = state;
      w_mb_nxt          = w_mb;
      h_mb_nxt          = h_mb;
      mb_x_nxt          = mb_x;
      mb_y_nxt          = mb_y;
      blk_idx_nxt       = blk_idx;
      intra_valid_nxt   = intra_valid;
      topleft_x_nxt     = topleft_x;
      topleft_y_nxt     = topleft_y;
      frame_done_nxt    = 1'b0;
      blk_done_cnt_nxt  = retire ? blk_done_cnt + 16'd1 : blk_done_cnt;
      err_underflow_nxt = err_underflow | underflow_hit;

      case (state)
         IDLE: begin
            if (start) begin
               if ((frame_w_mb != 6'd0) && (frame_h_mb != 6'd0)) begin
                  w_mb_nxt         = frame_w_mb;
                  h_mb_nxt         = frame_h_mb;
                  mb_x_nxt         = '0;
                  mb_y_nxt         = '0;
                  blk_idx_nxt      = '0;
                  blk_done_cnt_nxt = '0;
                  intra_valid_nxt  = room;
                  topleft_x_nxt    = '0;
                  topleft_y_nxt    = '0;
                  state_nxt        = RUN;
               end else begin
                  frame_done_nxt = 1'b1;
               end
            end
         end

         RUN: begin
            if (xfer) begin
               if (last_blk) begin
                  intra_valid_nxt = 1'b0;
                  mb_x_nxt        = '0;
                  mb_y_nxt        = '0;
                  blk_idx_nxt     = '0;
                  state_nxt       = DRAIN;
               end else begin
                  // Coordinates track the next block even while the in-flight limit holds it back.
                  mb_x_nxt        = adv_mb_x;
                  mb_y_nxt        = adv_mb_y;
                  blk_idx_nxt     = adv_blk;
                  intra_valid_nxt = room;
                  topleft_x_nxt   = px_x(adv_mb_x, adv_blk);
                  topleft_y_nxt   = px_y(adv_mb_y, adv_blk);
               end
            end else if (!intra_valid) begin
               intra_valid_nxt = room;
               topleft_x_nxt   = px_x(mb_x, blk_idx);
               topleft_y_nxt   = px_y(mb_y, blk_idx);
            end
         end

         DRAIN: begin
            intra_valid_nxt = 1'b0;
            if (inflight_nxt == '0) begin
               frame_done_nxt = 1'b1;
               state_nxt      = IDLE;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_mb          <= '0;
         h_mb          <= '0;
         mb_x          <= '0;
         mb_y          <= '0;
         blk_idx       <= '0;
         inflight      <= '0;
         intra_valid   <= 1'b0;
         topleft_x     <= '0;
         topleft_y     <= '0;
         frame_done    <= 1'b0;
         blk_done_cnt  <= '0;
         err_underflow <= 1'b0;
      end else begin
         w_mb          <= w_mb_nxt;
         h_mb          <= h_mb_nxt;
         mb_x          <= mb_x_nxt;
         mb_y          <= mb_y_nxt;
         blk_idx       <= blk_idx_nxt;
         inflight      <= inflight_nxt;
         intra_valid   <= intra_valid_nxt;
         topleft_x     <= topleft_x_nxt;
         topleft_y     <= topleft_y_nxt;
         frame_done    <= frame_done_nxt;
         blk_done_cnt  <= blk_done_cnt_nxt;
         err_underflow <= err_underflow_nxt;
      end
   end

endmodule

// File: tb/tb_cavlc_blk_sched.sv
// tb_cavlc_blk_sched: directed stimulus with a frame-level reference model checked every
// cycle on the falling edge, plus literal expectations for coordinates and counts.
module tb_cavlc_blk_sched;

   localparam int MAX_INFLIGHT = 2;
   localparam int CNT_W        = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [5:0]  frame_w_mb, frame_h_mb;
   logic        cavlc_cnt_ready, cavlc_enc_valid, packer_ready;
   logic        intra_valid;
   logic [9:0]  topleft_x, topleft_y;
   logic        busy, frame_done, err_underflow;
   logic [15:0] blk_done_cnt;

   cavlc_blk_sched #(.MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .frame_w_mb      (frame_w_mb),
      .frame_h_mb      (frame_h_mb),
      .cavlc_cnt_ready (cavlc_cnt_ready),
      .cavlc_enc_valid (cavlc_enc_valid),
      .packer_ready    (packer_ready),
      .intra_valid     (intra_valid),
      .topleft_x       (topleft_x),
      .topleft_y       (topleft_y),
      .busy            (busy),
      .frame_done      (frame_done),
      .blk_done_cnt    (blk_done_cnt),
      .err_underflow   (err_underflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // retire scheduling: each transfer is retired ret_delay cycles later
   int ret_q[$];
   int ret_delay  = 2;
   bit packer_en  = 1'b1;
   bit manual_ret = 1'b0;

   // reference model state
   int ex_x[$], ex_y[$];
   int log_x[$], log_y[$];
   int m_inflight, m_cnt, m_issued, m_total;
   bit m_busy, m_err, exp_fd;
   bit prev_stall;
   int prev_x, prev_y;
   int fd_count  = 0;
   int first_cyc = -1;
   int last_cyc  = -1;
   bit xfer_s, ret_s;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (!manual_ret) begin
         if (ret_q.size() > 0 && ret_q[0] <= cyc) begin
            cavlc_enc_valid = 1'b1;
            packer_ready    = packer_en;
            if (packer_en) void'(ret_q.pop_front());
         end else begin
            cavlc_enc_valid = 1'b0;
            packer_ready    = 1'b0;
         end
      end
   endtask

   task automatic do_start(input int w, input int h);
      frame_w_mb = 6'(w);
      frame_h_mb = 6'(h);
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int base = fd_count;
      int n    = 0;
      while (fd_count == base && n < budget) begin
         tick();
         n++;
      end
      check("frame_done_within_budget", int'(fd_count != base), 1);
   endtask

   // Frame-level model: expected block order, in-flight count, retire count, completion.
   always @(negedge clk) begin
      if (rst) begin
         m_inflight = 0; m_cnt = 0; m_issued = 0; m_total = 0;
         m_busy = 1'b0; m_err = 1'b0; exp_fd = 1'b0; prev_stall = 1'b0;
         ex_x.delete(); ex_y.delete();
      end else begin
         xfer_s = intra_valid && cavlc_cnt_ready;
         ret_s  = cavlc_enc_valid && packer_ready;

         check("busy", int'(busy), int'(m_busy));
         check("blk_done_cnt", int'(blk_done_cnt), m_cnt);
         check("err_underflow", int'(err_underflow), int'(m_err));
         check("frame_done", int'(frame_done), int'(exp_fd));
         if (frame_done) fd_count++;
         if (intra_valid)
            check("issue_allowed", int'(m_busy && (m_inflight < MAX_INFLIGHT)), 1);
         if (prev_stall) begin
            check("hold_valid", int'(intra_valid), 1);
            check("hold_x", int'(topleft_x), prev_x);
            check("hold_y", int'(topleft_y), prev_y);
         end

         if (xfer_s) begin
            check("xfer_in_frame", int'(m_issued < m_total), 1);
            if (ex_x.size() > 0) begin
               check("xfer_x", int'(topleft_x), ex_x[0]);
               check("xfer_y", int'(topleft_y), ex_y[0]);
               void'(ex_x.pop_front());
               void'(ex_y.pop_front());
            end
            log_x.push_back(int'(topleft_x));
            log_y.push_back(int'(topleft_y));
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            m_issued++;
            ret_q.push_back(cyc + ret_delay);
         end

         prev_stall = intra_valid && !cavlc_cnt_ready;
         prev_x     = int'(topleft_x);
         prev_y     = int'(topleft_y);

         if (ret_s) begin
            m_cnt++;
            if (m_inflight == 0) m_err = 1'b1;
            else m_inflight--;
         end
         if (xfer_s) m_inflight++;

         exp_fd = 1'b0;
         if (start && !m_busy) begin
            if (frame_w_mb != 6'd0 && frame_h_mb != 6'd0) begin
               m_busy = 1'b1; m_cnt = 0; m_issued = 0;
               m_total = int'(frame_w_mb) * int'(frame_h_mb) * 16;
               ex_x.delete(); ex_y.delete(); log_x.delete(); log_y.delete();
               first_cyc = -1; last_cyc = -1;
               for (int my = 0; my < int'(frame_h_mb); my++)
                  for (int mx = 0; mx < int'(frame_w_mb); mx++)
                     for (int b = 0; b < 16; b++) begin
                        ex_x.push_back(mx * 16 + 8 * ((b >> 2) & 1) + 4 * (b & 1));
                        ex_y.push_back(my * 16 + 8 * ((b >> 3) & 1) + 4 * ((b >> 1) & 1));
                     end
            end else begin
               exp_fd = 1'b1;
            end
         end else if (m_busy && m_issued == m_total && m_inflight == 0) begin
            exp_fd = 1'b1;
            m_busy = 1'b0;
         end
      end
   end

   int lit_x[16] = '{0, 4, 0, 4, 8, 12, 8, 12, 0, 4, 0, 4, 8, 12, 8, 12};
   int lit_y[16] = '{0, 0, 4, 4, 0, 0, 4, 4, 8, 8, 12, 12, 8, 8, 12, 12};
   int base_fd;

   initial begin
      rst = 1'b1; start = 1'b0; frame_w_mb = '0; frame_h_mb = '0;
      cavlc_cnt_ready = 1'b0; cavlc_enc_valid = 1'b0; packer_ready = 1'b0;
      #2;
      check("rst_intra_valid", int'(intra_valid), 0);
      check("rst_topleft_x", int'(topleft_x), 0);
      check("rst_topleft_y", int'(topleft_y), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_frame_done", int'(frame_done), 0);
      check("rst_blk_done_cnt", int'(blk_done_cnt), 0);
      check("rst_err_underflow", int'(err_underflow), 0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // single MB, retire two cycles after each issue
      cavlc_cnt_ready = 1'b1;
      ret_delay = 2;
      do_start(1, 1);
      wait_done(300);
      check("mb1_xfers", log_x.size(), 16);
      for (int i = 0; i < 16; i++) begin
         check("mb1_lit_x", log_x[i], lit_x[i]);
         check("mb1_lit_y", log_y[i], lit_y[i]);
      end
      check("mb1_blk_done_cnt", int'(blk_done_cnt), 16);
      check("mb1_frame_done_pulses", fd_count, 1);

      // 2x2 raster walk, back-to-back issue, start pulsed mid-run
      ret_delay = 1;
      do_start(2, 2);
      repeat (10) tick();
      frame_w_mb = 6'd1; frame_h_mb = 6'd1; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(400);
      check("raster_xfers", log_x.size(), 64);
      check("raster_33rd_x", log_x[32], 0);
      check("raster_33rd_y", log_y[32], 16);
      check("raster_last_x", log_x[63], 28);
      check("raster_last_y", log_y[63], 28);
      check("raster_blk_done_cnt", int'(blk_done_cnt), 64);
      check("raster_back_to_back", last_cyc - first_cyc, 63);
      check("raster_frame_done_pulses", fd_count, 2);

      // in-flight limit with the packer stalled
      ret_delay = 1;
      packer_en = 1'b0;
      do_start(2, 1);
      repeat (8) tick();
      check("limit_xfers", log_x.size(), 2);
      check("limit_valid_low", int'(intra_valid), 0);
      check("limit_next_x", int'(topleft_x), 0);
      check("limit_next_y", int'(topleft_y), 4);
      repeat (3) tick();
      check("limit_still_2", log_x.size(), 2);
      check("limit_stable_y", int'(topleft_y), 4);
      packer_en = 1'b1;
      wait_done(300);
      check("limit_total_xfers", log_x.size(), 32);
      check("limit_resume_x", log_x[2], 0);
      check("limit_resume_y", log_y[2], 4);
      check("limit_blk_done_cnt", int'(blk_done_cnt), 32);

      // backpressure on the (16,0) request
      do_start(2, 1);
      begin
         int n = 0;
         while (!(intra_valid && topleft_x == 10'd16) && n < 100) begin
            tick();
            n++;
         end
      end
      cavlc_cnt_ready = 1'b0;
      check("bp_reached", int'(intra_valid && topleft_x == 10'd16), 1);
      check("bp_prior_xfers", log_x.size(), 16);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_valid", int'(intra_valid), 1);
         check("bp_hold_x", int'(topleft_x), 16);
         check("bp_no_xfer", log_x.size(), 16);
      end
      cavlc_cnt_ready = 1'b1;
      tick();
      check("bp_xfer_on_ready", log_x.size(), 17);
      check("bp_xfer_x", log_x[16], 16);
      wait_done(300);
      check("bp_frame_done_pulses", fd_count, 4);

      // zero-size frames
      do_start(0, 3);
      check("zero_w_frame_done", int'(frame_done), 1);
      check("zero_w_busy", int'(busy), 0);
      tick();
      check("zero_w_pulse_ends", int'(frame_done), 0);
      do_start(5, 0);
      check("zero_h_frame_done", int'(frame_done), 1);
      check("zero_h_busy", int'(busy), 0);
      tick();

      // retire with nothing in flight
      manual_ret = 1'b1;
      cavlc_enc_valid = 1'b1; packer_ready = 1'b1;
      tick();
      cavlc_enc_valid = 1'b0; packer_ready = 1'b0;
      check("underflow_set", int'(err_underflow), 1);
      check("underflow_cnt", int'(blk_done_cnt), 33);
      tick();
      check("underflow_sticky", int'(err_underflow), 1);
      manual_ret = 1'b0;

      // async reset mid-frame
      ret_delay = 2;
      do_start(2, 2);
      repeat (20) tick();
      check("pre_rst_busy", int'(busy), 1);
      check("pre_rst_cnt_nonzero", int'(blk_done_cnt != 16'd0), 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_intra_valid", int'(intra_valid), 0);
      check("async_rst_topleft_x", int'(topleft_x), 0);
      check("async_rst_topleft_y", int'(topleft_y), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_frame_done", int'(frame_done), 0);
      check("async_rst_blk_done_cnt", int'(blk_done_cnt), 0);
      check("async_rst_err_underflow", int'(err_underflow), 0);
      ret_q.delete();
      tick(); tick();
      rst = 1'b0;
      base_fd = fd_count;
      repeat (6) tick();
      check("post_rst_no_frame_done", fd_count, base_fd);
      check("post_rst_busy", int'(busy), 0);
      check("post_rst_intra_valid", int'(intra_valid), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
